// File: rtl/cs_region_decode_if.sv
// Bus bundle for cs_region_decode: CPU address/strobe inputs,
// window-table config port, latched selects and status outputs.
interface cs_region_decode_if #(
  parameter int ADDR_W = 23,
  parameter int TAG_W  = 4,
  parameter int NREG   = 8
);
  logic [ADDR_W:1]   A;
  logic              nWE;
  logic              BACT;
  logic              QoSEN;
  logic              OvlSet;
  logic              CfgWE;
  logic [3:0]        CfgIdx;
  logic [TAG_W-1:0]  CfgBase;
  logic [TAG_W-1:0]  CfgMask;
  logic [2:0]        CfgAttr;
  logic [NREG-1:0]   RegionHit;
  logic              IOCS;
  logic              IOPWCS;
  logic              ROMCS;
  logic              RAMCS;
  logic              Miss;
  logic              Overlay;
  logic              QoSActive;

  modport master (
    output A, nWE, BACT, QoSEN, OvlSet,
    output CfgWE, CfgIdx, CfgBase,
    output CfgMask, CfgAttr,
    input  RegionHit, IOCS, IOPWCS,
    input  ROMCS, RAMCS, Miss,
    input  Overlay, QoSActive
  );

  modport slave (
    input  A, nWE, BACT, QoSEN, OvlSet,
    input  CfgWE, CfgIdx, CfgBase,
    input  CfgMask, CfgAttr,
    output RegionHit, IOCS, IOPWCS,
    output ROMCS, RAMCS, Miss,
    output Overlay, QoSActive
  );
endinterface

// File: rtl/cs_region_decode.sv
// Programmable chip-select decoder. Ports: CLK, nRES (async low),
// bus (slave): A/nWE/BACT/QoSEN/OvlSet, Cfg* table port, selects.
module cs_region_decode #(
  parameter int ADDR_W = 23,
  parameter int TAG_W  = 4,
  parameter int NREG   = 8,
  parameter logic [TAG_W-1:0] ROM_TAG = TAG_W'(4'h4),
  parameter int OVL_CLR_CNT = 1,
  parameter int QOS_ON  = 4,
  parameter int QOS_OFF = 8
) (
  input logic CLK,
  input logic nRES,
  cs_region_decode_if.slave bus
);
  localparam int LSB = ADDR_W - TAG_W + 1;

  logic [TAG_W-1:0] r_base [NREG];
  logic [TAG_W-1:0] r_mask [NREG];
  logic [2:0]       r_attr [NREG];

  logic            r_bact;
  logic [NREG-1:0] r_hit;
  logic            r_io;
  logic            r_pw;
  logic            r_rom;
  logic            r_ram;
  logic            r_miss;
  logic            r_ovl;
  logic [3:0]      r_ocnt;
  logic            r_qos;
  logic [7:0]      r_qcnt;

  logic [TAG_W-1:0] w_tag;
  logic [NREG-1:0]  w_hit;
  logic [NREG-1:0]  w_one;
  logic             w_io;
  logic             w_pw;
  logic             w_any;
  logic             w_rom;
  logic             w_ram;
  logic             w_rise;
  logic             w_romtag;
  logic [3:0]       w_onx;
  logic [8:0]       w_qnx;
  logic [7:0]       w_qthr;
  logic             w_unused;

  assign w_tag    = bus.A[ADDR_W:LSB];
  assign w_unused = ^bus.A;
  assign w_romtag = (w_tag == ROM_TAG);
  assign w_rom    = r_ovl || w_romtag;
  assign w_ram    = (bus.A[ADDR_W:ADDR_W-1] == 2'b00)
                    && !r_ovl;
  assign w_rise   = bus.BACT && !r_bact;
  assign w_any    = |w_hit;
  assign w_onx    = r_ocnt + 4'd1;
  assign w_qnx    = {1'b0, r_qcnt} + 9'd1;
  assign w_qthr   = r_qos ? 8'(QOS_OFF) : 8'(QOS_ON);

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NREG; i++) begin
      w_hit[i] = r_attr[i][2] &&
        (((w_tag ^ r_base[i]) & r_mask[i]) == '0);
    end
  end

  // Scan downward so the lowest-index hit is assigned last.
  always_comb begin
    w_one = '0;
    w_io  = 1'b0;
    w_pw  = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_one    = '0;
        w_one[i] = 1'b1;
        w_io     = r_attr[i][1];
        w_pw     = r_attr[i][0];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      for (int i = 0; i < NREG; i++) begin
        r_base[i] <= '0;
        r_mask[i] <= '0;
        r_attr[i] <= '0;
      end
    end else if (bus.CfgWE) begin
      for (int i = 0; i < NREG; i++) begin
        if (bus.CfgIdx == 4'(i)) begin
          r_base[i] <= bus.CfgBase;
          r_mask[i] <= bus.CfgMask;
          r_attr[i] <= bus.CfgAttr;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      r_bact <= 1'b0;
      r_hit  <= '0;
      r_io   <= 1'b0;
      r_pw   <= 1'b0;
      r_rom  <= 1'b0;
      r_ram  <= 1'b0;
      r_miss <= 1'b0;
    end else begin
      r_bact <= bus.BACT;
      unique case (1'b1)
        w_rise: begin
          r_hit  <= w_one;
          r_rom  <= w_rom;
          r_ram  <= w_ram;
          r_io   <= w_io || (w_pw && !bus.nWE)
                    || r_qos;
          r_pw   <= w_pw && !bus.nWE && !r_qos;
          r_miss <= !w_any && !w_rom && !w_ram;
        end
        !bus.BACT: begin
          r_hit  <= '0;
          r_io   <= 1'b0;
          r_pw   <= 1'b0;
          r_rom  <= 1'b0;
          r_ram  <= 1'b0;
          r_miss <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Re-arm wins over a clear landing on the same edge.
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      r_ovl  <= 1'b1;
      r_ocnt <= '0;
    end else if (bus.OvlSet) begin
      r_ovl  <= 1'b1;
      r_ocnt <= '0;
    end else if (w_rise && w_romtag && r_ovl) begin
      if (w_onx == 4'(OVL_CLR_CNT)) begin
        r_ovl  <= 1'b0;
        r_ocnt <= '0;
      end else begin
        r_ocnt <= w_onx;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      r_qos  <= 1'b0;
      r_qcnt <= '0;
    end else if (bus.QoSEN == r_qos) begin
      r_qcnt <= '0;
    end else if (w_qnx >= {1'b0, w_qthr}) begin
      r_qos  <= !r_qos;
      r_qcnt <= '0;
    end else if (r_qcnt != 8'hFF) begin
      r_qcnt <= w_qnx[7:0];
    end
  end

  assign bus.RegionHit = r_hit;
  assign bus.IOCS      = r_io;
  assign bus.IOPWCS    = r_pw;
  assign bus.ROMCS     = r_rom;
  assign bus.RAMCS     = r_ram;
  assign bus.Miss      = r_miss;
  assign bus.Overlay   = r_ovl;
  assign bus.QoSActive = r_qos;
endmodule

// File: tb/tb_cs_region_decode.sv
// Directed bench for cs_region_decode: expected selects are queued
// at each bus-cycle start and popped when the latched outputs appear.
module tb_cs_region_decode;
  logic CLK = 1'b0;
  logic nRES = 1'b1;

  cs_region_decode_if bus ();

  cs_region_decode dut (
    .CLK  (CLK),
    .nRES (nRES),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] hit;
    logic io;
    logic pw;
    logic rom;
    logic ram;
    logic miss;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] h,
    input logic io, input logic pw, input logic rom,
    input logic ram, input logic miss);
    exp_t e;
    e.hit = h; e.io = io; e.pw = pw;
    e.rom = rom; e.ram = ram; e.miss = miss;
    return e;
  endfunction

  task automatic cmp_out(input string tag, input exp_t e);
    chk({tag, ".hit"}, 32'(bus.RegionHit), 32'(e.hit));
    chk({tag, ".io"},  32'(bus.IOCS),   32'(e.io));
    chk({tag, ".pw"},  32'(bus.IOPWCS), 32'(e.pw));
    chk({tag, ".rom"}, 32'(bus.ROMCS),  32'(e.rom));
    chk({tag, ".ram"}, 32'(bus.RAMCS),  32'(e.ram));
    chk({tag, ".miss"}, 32'(bus.Miss),  32'(e.miss));
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 32'({bus.RegionHit, bus.IOCS, bus.IOPWCS,
                  bus.ROMCS, bus.RAMCS, bus.Miss}), 32'd0);
  endtask

  function automatic exp_t pop();
    exp_t e;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic access(input string tag,
                        input logic [23:0] ba,
                        input bit wr, input bit ovs,
                        input exp_t e, input int hold);
    exp_t got;
    @(negedge CLK);
    bus.A = ba[23:1];
    bus.nWE = ~wr;
    bus.BACT = 1'b1;
    bus.OvlSet = ovs;
    sb.push_back(e);
    @(posedge CLK); #1;
    got = pop();
    cmp_out(tag, got);
    @(negedge CLK);
    bus.OvlSet = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(posedge CLK); #1;
      cmp_out({tag, ".hold"}, got);
      @(negedge CLK);
    end
    bus.BACT = 1'b0;
    @(posedge CLK); #1;
    chk_idle({tag, ".clr"});
  endtask

  task automatic cfg(input logic [3:0] idx,
                     input logic [3:0] base,
                     input logic [3:0] mask,
                     input logic [2:0] attr);
    @(negedge CLK);
    bus.CfgWE = 1'b1;
    bus.CfgIdx = idx;
    bus.CfgBase = base;
    bus.CfgMask = mask;
    bus.CfgAttr = attr;
    @(negedge CLK);
    bus.CfgWE = 1'b0;
  endtask

  task automatic qos_run(input logic lvl, input int n);
    @(negedge CLK);
    bus.QoSEN = lvl;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    exp_t e;
    bus.A = '0;
    bus.nWE = 1'b1;
    bus.BACT = 1'b0;
    bus.QoSEN = 1'b0;
    bus.OvlSet = 1'b0;
    bus.CfgWE = 1'b0;
    bus.CfgIdx = '0;
    bus.CfgBase = '0;
    bus.CfgMask = '0;
    bus.CfgAttr = '0;

    #1 nRES = 1'b0;
    #2;
    chk_idle("rst.sel");
    chk("rst.ovl", 32'(bus.Overlay), 32'd1);
    chk("rst.qos", 32'(bus.QoSActive), 32'd0);
    @(negedge CLK);
    nRES = 1'b1;

    access("rom0", 24'h400000, 0, 0,
           mk(8'h00, 0, 0, 1, 0, 0), 1);
    chk("ovl.clr", 32'(bus.Overlay), 32'd0);
    access("ram0", 24'h000000, 0, 0,
           mk(8'h00, 0, 0, 0, 1, 0), 0);

    cfg(4'd0, 4'hE, 4'hF, 3'b110);
    cfg(4'd1, 4'hC, 4'hC, 3'b100);
    access("winE", 24'hE00000, 0, 0,
           mk(8'h01, 1, 0, 0, 0, 0), 0);
    access("winD", 24'hD00000, 0, 0,
           mk(8'h02, 0, 0, 0, 0, 0), 0);
    access("miss6", 24'h600000, 0, 0,
           mk(8'h00, 0, 0, 0, 0, 1), 0);

    cfg(4'd2, 4'h3, 4'hF, 3'b101);
    access("pw", 24'h3FA100, 1, 0,
           mk(8'h04, 1, 1, 0, 1, 0), 0);

    qos_run(1'b1, 3);
    chk("qos.h3", 32'(bus.QoSActive), 32'd0);
    qos_run(1'b0, 1);
    chk("qos.l1", 32'(bus.QoSActive), 32'd0);
    qos_run(1'b1, 3);
    chk("qos.h3b", 32'(bus.QoSActive), 32'd0);
    @(posedge CLK); #1;
    chk("qos.h4", 32'(bus.QoSActive), 32'd1);
    qos_run(1'b0, 7);
    chk("qos.l7", 32'(bus.QoSActive), 32'd1);
    qos_run(1'b1, 1);
    chk("qos.hold", 32'(bus.QoSActive), 32'd1);

    access("pwq", 24'h3FA100, 1, 0,
           mk(8'h04, 1, 0, 0, 1, 0), 0);

    qos_run(1'b0, 7);
    chk("qos.off7", 32'(bus.QoSActive), 32'd1);
    @(posedge CLK); #1;
    chk("qos.off8", 32'(bus.QoSActive), 32'd0);

    @(negedge CLK);
    bus.OvlSet = 1'b1;
    @(negedge CLK);
    bus.OvlSet = 1'b0;
    chk("ovl.set", 32'(bus.Overlay), 32'd1);
    access("romset", 24'h400000, 0, 1,
           mk(8'h00, 0, 0, 1, 0, 0), 0);
    chk("ovl.keep", 32'(bus.Overlay), 32'd1);
    access("rom1", 24'h400000, 0, 0,
           mk(8'h00, 0, 0, 1, 0, 0), 0);
    chk("ovl.clr2", 32'(bus.Overlay), 32'd0);

    cfg(4'd8, 4'h6, 4'hF, 3'b110);
    access("idx8", 24'h600000, 0, 0,
           mk(8'h00, 0, 0, 0, 0, 1), 0);

    @(negedge CLK);
    bus.A = 23'(24'hE00000 >> 1);
    bus.nWE = 1'b1;
    bus.BACT = 1'b1;
    sb.push_back(mk(8'h01, 1, 0, 0, 0, 0));
    @(posedge CLK); #1;
    e = pop();
    cmp_out("pre", e);
    #2 nRES = 1'b0;
    #1;
    chk_idle("arst.sel");
    chk("arst.ovl", 32'(bus.Overlay), 32'd1);
    @(negedge CLK);
    bus.BACT = 1'b0;
    @(negedge CLK);
    nRES = 1'b1;
    access("post", 24'hE00000, 0, 0,
           mk(8'h00, 0, 0, 1, 0, 0), 0);
    chk("post.ovl", 32'(bus.Overlay), 32'd1);

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cs_region_decode.md
Name: cs_region_decode

Overview:
- Parametrised successor to the fixed chip-select decoder: NREG software-programmable address windows replace the hard-wired I/O map.
- Adds per-cycle latched selects, an overlay-exit counter with software re-arm, QoS enable hysteresis and a latched unmapped-access (Miss) flag.
- Sits between the MC68HC000 address bus and the IOB / RAM / ROM bridges.

Parameters:
- ADDR_W, 23: highest CPU address bit; address port is A[ADDR_W:1].
- TAG_W, 4: number of upper address bits compared per window; tag = A[ADDR_W:ADDR_W-TAG_W+1].
- NREG, 8: number of programmable windows (1..16).
- ROM_TAG, 4'h4: tag of the permanent ROM region.
- OVL_CLR_CNT, 1: ROM-region bus cycles required to clear Overlay (1..15).
- QOS_ON, 4: consecutive QoSEN-high cycles before QoS becomes active (1..15).
- QOS_OFF, 8: consecutive QoSEN-low cycles before QoS becomes inactive (1..255).

Ports:
- CLK, input, 1: system clock.
- nRES, input, 1: reset; asynchronous, active-low.
- A, input, ADDR_W: CPU address A[ADDR_W:1].
- nWE, input, 1: CPU write strobe, low = write.
- BACT, input, 1: bus cycle active.
- QoSEN, input, 1: raw QoS request.
- OvlSet, input, 1: one-cycle pulse that re-arms Overlay.
- CfgWE, input, 1: window table write strobe.
- CfgIdx, input, 4: window index to write.
- CfgBase, input, TAG_W: window base tag.
- CfgMask, input, TAG_W: window compare mask; 1 = bit compared.
- CfgAttr, input, 3: {EN, IO, PW}.
- RegionHit, output, NREG: latched one-hot window hit.
- IOCS, output, 1: latched I/O select.
- IOPWCS, output, 1: latched posted-write select.
- ROMCS, output, 1: latched ROM select.
- RAMCS, output, 1: latched RAM select.
- Miss, output, 1: latched unmapped-access flag.
- Overlay, output, 1: overlay state.
- QoSActive, output, 1: filtered QoS state.

Behaviour:
- Reset (nRES low, asynchronous):
  - All table entries cleared, with EN=0.
  - Overlay=1; overlay counter=0.
  - QoSActive=0; QoS counter=0.
  - All latched outputs 0.
  - BACT edge register cleared to 0.
- Table write:
  - On a CLK edge with CfgWE=1 and CfgIdx<NREG, entry CfgIdx = {CfgBase, CfgMask, CfgAttr}.
  - CfgIdx>=NREG: write ignored.
  - A write applies to compares from the next cycle. It never alters outputs already latched.
- Combinational decode:
  - hit_i = EN_i && ((tag ^ base_i) & mask_i)==0.
  - Priority: the lowest-index hit wins; the winning window is w.
  - rom = Overlay || tag==ROM_TAG.
  - ram = A[ADDR_W:ADDR_W-1]==0 && !Overlay.
  - Both windows and rom/ram may match; all corresponding outputs assert.
- Latch point:
  - A BACT rising edge is detected as BACT=1 while registered BACT=0.
  - On that cycle's CLK edge, the following register:
    - RegionHit = onehot(w), or 0 if there is no hit.
    - ROMCS = rom; RAMCS = ram.
    - IOCS = IO_w || (PW_w && !nWE) || QoSActive.
    - IOPWCS = PW_w && !nWE && !QoSActive.
    - Miss = no window hit && !rom && !ram.
  - Latency: one CLK from the BACT rise.
  - Outputs hold while BACT=1 and clear to 0 on the CLK edge where BACT is sampled 0.
  - Back-to-back cycles need at least one BACT-low sample.
- Overlay:
  - On each latch with tag==ROM_TAG and Overlay=1, the counter increments.
  - When the increment reaches OVL_CLR_CNT, Overlay becomes 0 on the same edge and the counter returns to 0.
  - OvlSet=1: Overlay=1 and counter=0. This overrides a simultaneous clear.
  - The Overlay value used for a latch is the pre-edge value.
- QoS filter:
  - Counter resets whenever QoSEN equals QoSActive.
  - Otherwise the counter increments. On reaching QOS_ON (when inactive) or QOS_OFF (when active), QoSActive toggles and the counter resets.
  - The counter saturates; it never wraps.
  - The pre-edge QoSActive value feeds the latch.

Test Plan:
- Reset, then a read at tag 4 with BACT rising: ROMCS=1, RAMCS=0 one cycle later; Overlay=0 after that edge (OVL_CLR_CNT=1); a following read at 0x000000 gives RAMCS=1, ROMCS=0.
- Program idx0 {base 4'hE, mask 4'hF, EN IO}, idx1 {base 4'hC, mask 4'hC, EN}; access tag E -> RegionHit=8'h01, IOCS=1; access tag D -> RegionHit=8'h02, IOCS=0 (QoSActive=0); access tag 6 -> Miss=1.
- Window {base 3, mask F, EN PW}, write at 0x3FA100, QoSActive=0: IOPWCS=1, IOCS=1. Hold QoSEN=1 for 4 cycles, then repeat: IOPWCS=0, IOCS=1.
- QoSEN toggled high 3 cycles then low: QoSActive stays 0. High 4 cycles: QoSActive=1. Low 7 cycles then high: QoSActive stays 1.
- OvlSet pulsed on the same edge as a ROM-tag latch that would clear Overlay: Overlay=1, counter=0. CfgWE with CfgIdx=NREG leaves the table unchanged.
- nRES asserted mid-cycle with BACT=1 and outputs latched: all selects drop to 0 without a CLK edge; Overlay=1 and the table is disabled after release.
